efb_wb_arbiter: RTL and testbench

Two-master Wishbone arbiter in front of the MachXO2 EFB slave port. It lets the UFM read path (streamer) and a second EFB user (UFM writer/eraser or config controller) share one EFB, with round-robin fairness and bus ownership held for a whole `cyc` tenure. An ack watchdog makes sure a hung access cannot lock the EFB.

---
 rtl/efb_pkg.sv | 22 ++
 rtl/efb_ack_watchdog.sv | 45 ++++
 rtl/efb_wb_arbiter.sv | 149 ++++++++++++++
 tb/tb_efb_wb_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/efb_pkg.sv
// ============================================================================
// efb_pkg: shared widths and arbiter state encoding for the EFB bus. Rev 1.0
// ============================================================================
`default_nettype none

package efb_pkg;

  localparam int EFB_ADR_W = 8;
  localparam int EFB_DAT_W = 8;
  localparam int WDOG_W    = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GRANT0  = 3'd1,
    ST_GRANT1  = 3'd2,
    ST_ABORT   = 3'd3,
    ST_RELEASE = 3'd4
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/efb_ack_watchdog.sv
// ============================================================================
// efb_ack_watchdog: saturating counter flagging a strobe left unacked. Rev 1.0
// ============================================================================
`default_nettype none

module efb_ack_watchdog
  import efb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic stb,
  input  logic ack,
  output logic expired
);

  localparam logic [WDOG_W-1:0] LIMIT_M1 = WDOG_W'(TIMEOUT_CYCLES - 1);

  logic [WDOG_W-1:0] cnt_q;
  logic [WDOG_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!stb || ack) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires in the cycle the count would reach the limit; a same-cycle ack wins.
  assign expired = stb && !ack && (cnt_q >= LIMIT_M1);

endmodule

`default_nettype wire

// File: rtl/efb_wb_arbiter.sv
// ============================================================================
// efb_wb_arbiter: two-master round-robin Wishbone arbiter for the EFB. Rev 1.0
// ============================================================================
`default_nettype none

module efb_wb_arbiter
  import efb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 m0_cyc_i,
  input  logic                 m0_stb_i,
  input  logic                 m0_we_i,
  input  logic [EFB_ADR_W-1:0] m0_adr_i,
  input  logic [EFB_DAT_W-1:0] m0_dat_i,
  output logic [EFB_DAT_W-1:0] m0_dat_o,
  output logic                 m0_ack_o,
  output logic                 m0_err_o,
  input  logic                 m1_cyc_i,
  input  logic                 m1_stb_i,
  input  logic                 m1_we_i,
  input  logic [EFB_ADR_W-1:0] m1_adr_i,
  input  logic [EFB_DAT_W-1:0] m1_dat_i,
  output logic [EFB_DAT_W-1:0] m1_dat_o,
  output logic                 m1_ack_o,
  output logic                 m1_err_o,
  output logic                 efb_cyc_o,
  output logic                 efb_stb_o,
  output logic                 efb_we_o,
  output logic [EFB_ADR_W-1:0] efb_adr_o,
  output logic [EFB_DAT_W-1:0] efb_dat_o,
  input  logic [EFB_DAT_W-1:0] efb_dat_i,
  input  logic                 efb_ack_i,
  output logic                 owner,
  output logic                 busy
);

  arb_state_e state_q;
  logic       last_q;
  logic       owner_q;
  logic       busy_q;
  logic       own_cyc;
  logic       wdog_expired;

  assign own_cyc = owner_q ? m1_cyc_i : m0_cyc_i;

  efb_ack_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .stb     (efb_stb_o),
    .ack     (efb_ack_i),
    .expired (wdog_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // On a tie the master not served last wins.
          if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
            state_q <= ST_GRANT0;
            last_q  <= 1'b0;
            owner_q <= 1'b0;
            busy_q  <= 1'b1;
          end else if (m1_cyc_i) begin
            state_q <= ST_GRANT1;
            last_q  <= 1'b1;
            owner_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_GRANT0, ST_GRANT1: begin
          if (!own_cyc) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (wdog_expired) begin
            state_q <= ST_ABORT;
          end
        end
        ST_ABORT: begin
          state_q <= ST_RELEASE;
        end
        ST_RELEASE: begin
          if (!own_cyc) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    efb_cyc_o = 1'b0;
    efb_stb_o = 1'b0;
    efb_we_o  = 1'b0;
    efb_adr_o = '0;
    efb_dat_o = '0;
    m0_ack_o  = 1'b0;
    m1_ack_o  = 1'b0;
    m0_err_o  = 1'b0;
    m1_err_o  = 1'b0;
    case (state_q)
      ST_GRANT0: begin
        efb_cyc_o = m0_cyc_i;
        efb_stb_o = m0_stb_i && m0_cyc_i;
        efb_we_o  = m0_we_i;
        efb_adr_o = m0_adr_i;
        efb_dat_o = m0_dat_i;
        m0_ack_o  = efb_ack_i;
      end
      ST_GRANT1: begin
        efb_cyc_o = m1_cyc_i;
        efb_stb_o = m1_stb_i && m1_cyc_i;
        efb_we_o  = m1_we_i;
        efb_adr_o = m1_adr_i;
        efb_dat_o = m1_dat_i;
        m1_ack_o  = efb_ack_i;
      end
      ST_ABORT: begin
        m0_err_o = !owner_q;
        m1_err_o = owner_q;
      end
      default: begin
      end
    endcase
  end

  assign m0_dat_o = efb_dat_i;
  assign m1_dat_o = efb_dat_i;
  assign owner    = owner_q;
  assign busy     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_efb_wb_arbiter.sv
// ============================================================================
// tb_efb_wb_arbiter: directed checks of the EFB arbiter (TIMEOUT_CYCLES=4). Rev 1.0
// ============================================================================
`default_nettype none

module tb_efb_wb_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       m0_cyc_i = 0, m0_stb_i = 0, m0_we_i = 0;
  logic [7:0] m0_adr_i = 0, m0_dat_i = 0;
  logic [7:0] m0_dat_o;
  logic       m0_ack_o, m0_err_o;
  logic       m1_cyc_i = 0, m1_stb_i = 0, m1_we_i = 0;
  logic [7:0] m1_adr_i = 0, m1_dat_i = 0;
  logic [7:0] m1_dat_o;
  logic       m1_ack_o, m1_err_o;
  logic       efb_cyc_o, efb_stb_o, efb_we_o;
  logic [7:0] efb_adr_o, efb_dat_o;
  logic [7:0] efb_dat_i = 0;
  logic       efb_ack_i = 0;
  logic       owner, busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  efb_wb_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .efb_cyc_o(efb_cyc_o), .efb_stb_o(efb_stb_o), .efb_we_o(efb_we_o),
    .efb_adr_o(efb_adr_o), .efb_dat_o(efb_dat_o),
    .efb_dat_i(efb_dat_i), .efb_ack_i(efb_ack_i),
    .owner(owner), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs settle after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_own;

    // Reset state
    step(); step();
    efb_dat_i = 8'h5A;
    #1;
    check("rst_efb_cyc", efb_cyc_o, 0);
    check("rst_efb_stb", efb_stb_o, 0);
    check("rst_efb_adr", efb_adr_o, 0);
    check("rst_busy", busy, 0);
    check("rst_owner", owner, 0);
    check("rst_m0_ack", m0_ack_o, 0);
    check("rst_m1_err", m1_err_o, 0);
    check("rst_m0_dat", m0_dat_o, 8'h5A);
    check("rst_m1_dat", m1_dat_o, 8'h5A);
    rst = 1'b1;
    step();

    // Tie after reset: m0 first, then m1 after one idle cycle
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 8'h11;
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 8'h22;
    #1;
    check("tie_pre_cyc", efb_cyc_o, 0);
    step();
    check("tie_owner0", owner, 0);
    check("tie_busy", busy, 1);
    check("tie_adr0", efb_adr_o, 8'h11);
    efb_ack_i = 1; efb_dat_i = 8'hC3;
    #1;
    check("tie_m0_ack", m0_ack_o, 1);
    check("tie_m1_ack", m1_ack_o, 0);
    check("tie_m0_dat", m0_dat_o, 8'hC3);
    step();
    efb_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    #1;
    check("tie_drop_cyc", efb_cyc_o, 0);
    step();
    check("tie_idle_busy", busy, 0);
    check("tie_idle_cyc", efb_cyc_o, 0);
    step();
    check("tie_owner1", owner, 1);
    check("tie_adr1", efb_adr_o, 8'h22);
    check("tie_cyc1", efb_cyc_o, 1);

    // Round-robin: both keep requesting, owner drops cyc for one cycle per tenure
    m0_cyc_i = 1; m0_stb_i = 1;
    for (int k = 0; k < 4; k++) begin
      exp_own = (k % 2 == 0);
      #1;
      check("rr_owner", owner, exp_own);
      check("rr_busy", busy, 1);
      check("rr_adr", efb_adr_o, exp_own ? 8'h22 : 8'h11);
      efb_ack_i = 1;
      #1;
      check("rr_ack_own", exp_own ? m1_ack_o : m0_ack_o, 1);
      check("rr_ack_other", exp_own ? m0_ack_o : m1_ack_o, 0);
      step();
      efb_ack_i = 0;
      if (exp_own) begin m1_cyc_i = 0; m1_stb_i = 0; end
      else begin m0_cyc_i = 0; m0_stb_i = 0; end
      step();
      check("rr_idle_busy", busy, 0);
      if (exp_own) begin m1_cyc_i = 1; m1_stb_i = 1; end
      else begin m0_cyc_i = 1; m0_stb_i = 1; end
      step();
    end
    check("rr_final_owner", owner, 1);
    m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    step(); step();

    // Timeout on m1 with TIMEOUT_CYCLES=4
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 8'h33;
    step();
    check("to_c1_stb", efb_stb_o, 1);
    step(); step(); step();
    check("to_c4_err", m1_err_o, 0);
    check("to_c4_cyc", efb_cyc_o, 1);
    step();
    check("to_c5_err", m1_err_o, 1);
    check("to_c5_ack", m1_ack_o, 0);
    check("to_c5_cyc", efb_cyc_o, 0);
    check("to_c5_stb", efb_stb_o, 0);
    check("to_c5_busy", busy, 1);
    step();
    check("to_c6_err", m1_err_o, 0);
    check("to_c6_cyc", efb_cyc_o, 0);
    efb_ack_i = 1;
    #1;
    check("to_late_ack", m1_ack_o, 0);
    step();
    check("to_rel_cyc", efb_cyc_o, 0);
    check("to_rel_busy", busy, 1);
    efb_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    step();
    check("to_idle_busy", busy, 0);

    // Ack arriving on the cycle the watchdog would expire
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 8'h70;
    step();
    check("race_adr", efb_adr_o, 8'h70);
    step(); step(); step();
    efb_ack_i = 1;
    #1;
    check("race_ack", m0_ack_o, 1);
    check("race_err", m0_err_o, 0);
    step();
    efb_ack_i = 0;
    #1;
    check("race_c5_err", m0_err_o, 0);
    check("race_c5_cyc", efb_cyc_o, 1);
    step(); step(); step();
    check("race_c8_err", m0_err_o, 0);
    step();
    check("race_c9_err", m0_err_o, 1);
    m0_cyc_i = 0; m0_stb_i = 0;
    step(); step();
    check("race_idle_busy", busy, 0);

    // Reset mid-transfer, then a tie must go to m0 again
    m0_cyc_i = 1; m0_stb_i = 1;
    step();
    check("mr_cyc", efb_cyc_o, 1);
    rst = 0; m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 8'h22;
    step();
    check("mr_cyc0", efb_cyc_o, 0);
    check("mr_stb0", efb_stb_o, 0);
    check("mr_busy0", busy, 0);
    check("mr_owner0", owner, 0);
    check("mr_ack0", m0_ack_o, 0);
    check("mr_err0", m0_err_o, 0);
    rst = 1;
    step();
    check("mr_tie_owner", owner, 0);
    check("mr_tie_busy", busy, 1);
    check("mr_tie_adr", efb_adr_o, 8'h70);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
